// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: parity-mode encodings and the
// receive FSM state type.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous, idle-high input line.
// Both flops reset to 1 so a line held in reset never looks like a start bit.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver: mid-bit sampling, optional parity, 1-2 stop bits,
// one-entry holding register. Define UART_RX_MAJORITY_EN for 2-of-3 sampling.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic rx_s;
  logic samp_bit;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Vote is taken one clock after the nominal sample point, so every sample
  // strobe (and therefore the commit) moves one clock later.
  localparam int MAJ_DLY = 1;
  logic rx_d1, rx_d2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_d1 <= 1'b1;
      rx_d2 <= 1'b1;
    end else begin
      rx_d1 <= rx_s;
      rx_d2 <= rx_d1;
    end
  end

  assign samp_bit = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
`else
  localparam int MAJ_DLY = 0;
  assign samp_bit = rx_s;
`endif

  localparam logic [CW-1:0] START_CNT = CW'(CLKS_PER_BIT / 2 - 1 + MAJ_DLY);
  localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  uart_rx_state_t       state_q, state_n;
  logic [CW-1:0]        cnt_q, cnt_n;
  logic [3:0]           bit_q, bit_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic                 par_q, par_n;
  logic                 frm_q, frm_n;
  logic                 tick;
  logic                 commit;
  logic                 par_xor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      frm_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      par_q   <= par_n;
      frm_q   <= frm_n;
    end
  end

  assign par_xor = (^shift_q) ^ samp_bit;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q + CW'(1);
    bit_n   = bit_q;
    shift_n = shift_q;
    par_n   = par_q;
    frm_n   = frm_q;
    commit  = 1'b0;
    tick    = (state_q == START) ? (cnt_q == START_CNT) : (cnt_q == LAST_CNT);

    case (state_q)
      IDLE: begin
        cnt_n = '0;
        if (en && !rx_s) begin
          state_n = START;
          bit_n   = '0;
          par_n   = 1'b0;
          frm_n   = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          cnt_n   = '0;
          state_n = samp_bit ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_n   = '0;
          shift_n = {samp_bit, shift_q[DATA_BITS-1:1]};
          bit_n   = bit_q + 4'd1;
          if (bit_q == LAST_DATA) begin
            bit_n   = '0;
            state_n = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          cnt_n   = '0;
          par_n   = (PARITY_MODE == PARITY_ODD) ? ~par_xor : par_xor;
          state_n = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          cnt_n = '0;
          bit_n = bit_q + 4'd1;
          if (!samp_bit) frm_n = 1'b1;
          if (bit_q == LAST_STOP) begin
            commit  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Dropping enable abandons any partial frame without touching the holding register.
    if (!en) begin
      state_n = IDLE;
      commit  = 1'b0;
    end
  end

  // Holding register: rx_valid/rx_ready transfer the word when both are high
  // on a rising clk edge; a new frame always overwrites whatever is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else if (commit) begin
      rx_data     <= shift_q;
      rx_valid    <= 1'b1;
      parity_err  <= par_q;
      frame_err   <= frm_q | ~samp_bit;
      overrun_err <= rx_valid & ~rx_ready;
    end else if (rx_valid && rx_ready) begin
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end
  end

  assign busy = (state_q != IDLE);

endmodule
